correlator_cmd_tx: RTL and testbench
====================================

// Module: correlator_cmd_tx
// PURPOSE
//  Host-side command transmitter for the intensity correlator's 1-byte UART command channel.
//  Queues command requests (opcode + 4-bit argument) in a small FIFO and packs each into {arg,op}.
//  Serialises each byte as 8N1, LSB first, on a bit-rate tick. Drives the correlator's RX line.
//  Used in host-emulation FPGAs and in closed-loop benches that pair this block with the correlator top.
// PARAMETERS
//  FIFO_DEPTH  4  command queue depth; power of 2, >=2
//  STOP_BITS   1  stop-bit periods per frame (1 or 2)
// PORTS
//  clk         in   1     system clock
//  reset_n     in   1     asynchronous active-low reset
//  baud_pulse  in   1     one-clk-wide tick, one per bit period (same tick that drives the correlator UART)
//  cmd_valid   in   1     command request
//  cmd_ready   out  1     queue can accept; transfer on cmd_valid&cmd_ready
//  cmd_op      in   4     opcode: 1=SET_ACTIVE_LINE, 2=SET_LEDS, 13=ENABLE_CAPTURE
//  cmd_arg     in   4     argument; becomes byte[7:4]
//  TX          out  1     serial line, idle high
//  busy        out  1     high while a frame is on the line or the queue is non-empty
//  fifo_count  out  $clog2(FIFO_DEPTH)+1   queued entries, excluding the frame on the line
//  cmd_error   out  1     one-clk pulse on a rejected opcode (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate): TX=1, cmd_ready=1, busy=0, fifo_count=0, cmd_error=0; FIFO cleared; state IDLE.
//  Push: on posedge clk with cmd_valid&cmd_ready, write byte {cmd_arg,cmd_op}. fifo_count increments the next cycle.
//  cmd_ready = !full. It is combinational from registered state, so a full queue rejects a push.
//  A push while full is ignored; the producer holds cmd_valid.
//  FSM states: IDLE, START, DATA, STOP. All transitions occur only on cycles with baud_pulse=1.
//   IDLE:  if queue non-empty on a baud_pulse: pop head into shift reg, TX<=0, ->START.
//   START: on baud_pulse: TX<=shift[0], bit_cnt<=0, ->DATA.
//   DATA:  on baud_pulse: if bit_cnt==7, TX<=1 and ->STOP; else shift right, TX<=next bit, bit_cnt++.
//   STOP:  held STOP_BITS periods. On the last stop baud_pulse: if queue non-empty, pop, TX<=0, ->START
//          (back-to-back, no idle gap); else ->IDLE with TX=1.
//  Each line level holds exactly one bit period. A frame is 1+8+STOP_BITS periods.
//  Latency: push into an empty idle queue -> TX falls on the first baud_pulse at least 1 clk after the push.
//  Simultaneous push and pop in one cycle: both occur. fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Push into an empty queue on a baud_pulse cycle is not popped that cycle (pop sees the registered empty).
//  baud_pulse held high for several clks is treated as one tick per clk. The driver guarantees a 1-clk pulse.
//  busy = (state!=IDLE) | (fifo_count!=0).
//  reset_n asserted mid-frame: the frame is truncated, TX returns high immediately, and queued commands are lost.
// CONFIGURATION
//  Macro CORRELATOR_CMD_TX_CHECK_EN:
//   defined: only opcodes 1, 2 and 13 are accepted. Any other opcode with cmd_valid&cmd_ready is dropped:
//            the FIFO is not written and cmd_error pulses high for 1 clk. cmd_ready is unaffected.
//   undefined: every opcode is queued and transmitted. cmd_error is tied to 0.
// TESTING
//  1 op=1,arg=3, baud_pulse every 8 clks -> TX per bit period: 0,1,0,0,0,1,1,0,0,1 (byte 0x31); busy falls after stop.
//  2 op=13,arg=1 then op=2,arg=2 pushed back-to-back -> frames 0x1D then 0x22 with no idle period between them;
//    fifo_count goes 2->1->0.
//  3 Five pushes with baud_pulse held low -> 4 accepted, cmd_ready=0 after the 4th, fifo_count=4, TX stays 1.
//  4 reset_n low during DATA bit 3 -> TX=1 within the same clk, fifo_count=0, cmd_ready=1.
//    Next push transmits a clean full frame.
//  5 CHECK_EN defined, op=5 pushed -> cmd_error=1 for 1 clk, fifo_count stays 0, TX idle.
//    CHECK_EN undefined -> byte 0x05 is sent.
//  6 Push coincident with the final stop baud_pulse of the previous frame, queue was empty ->
//    frame starts on the following baud_pulse (one idle bit period).

Source files
------------

// File: rtl/correlator_cmd_tx_if.sv
// correlator_cmd_tx_if: command request handshake between a host producer and correlator_cmd_tx
interface correlator_cmd_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       cmd_error;
  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready, cmd_error);
  modport slave (input cmd_valid, cmd_op, cmd_arg, output cmd_ready, cmd_error);
endinterface

// File: rtl/correlator_cmd_tx.sv
// correlator_cmd_tx: queued 8N1 command byte transmitter for the correlator RX line; CORRELATOR_CMD_TX_CHECK_EN enables opcode filtering
module correlator_cmd_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          baud_pulse,
  correlator_cmd_tx_if.slave            cmd,
  output logic                          TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic          tx_d, push, pop, empty, op_ok;
  assign empty         = count == '0;
  assign cmd.cmd_ready = count != CW'(FIFO_DEPTH);
  assign push          = cmd.cmd_valid & cmd.cmd_ready & op_ok;
  assign fifo_count    = count;
  assign busy          = (state_q != IDLE) | !empty;
`ifdef CORRELATOR_CMD_TX_CHECK_EN
  logic err_q;
  assign op_ok         = cmd.cmd_op inside {4'd1, 4'd2, 4'd13};
  assign cmd.cmd_error = err_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= cmd.cmd_valid & cmd.cmd_ready & !op_ok;
`else
  assign op_ok         = 1'b1;
  assign cmd.cmd_error = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd.cmd_arg, cmd.cmd_op};
  // pop only sees the registered queue state, so a same-cycle push is never popped
  always_comb begin
    state_d    = state_q;
    tx_d       = TX;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    pop        = 1'b0;
    if (baud_pulse) begin
      case (state_q)
        IDLE: if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          tx_d    = 1'b0;
          state_d = START;
        end
        START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end
        DATA: if (bit_cnt_q == 3'd7) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end else begin
          shift_d   = shift_q >> 1;
          tx_d      = shift_q[1];
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        STOP: if (stop_cnt_q != 1'(STOP_BITS - 1)) stop_cnt_d = 1'b1;
        else if (!empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      TX         <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state_q    <= state_d;
      TX         <= tx_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count      <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_correlator_cmd_tx.sv
// tb_correlator_cmd_tx: directed self-checking bench for correlator_cmd_tx
module tb_correlator_cmd_tx;
  logic       clk = 1'b0, reset_n = 1'b0, baud_pulse = 1'b0, baud_en = 1'b0;
  logic       TX, busy;
  logic [2:0] fifo_count;
  int         cyc = 0, bcnt = 0, pass_cnt = 0, total = 0;
  correlator_cmd_tx_if cmd();
  correlator_cmd_tx dut (
    .clk(clk), .reset_n(reset_n), .baud_pulse(baud_pulse), .cmd(cmd),
    .TX(TX), .busy(busy), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // one-clk baud tick every 8 clks while enabled
  initial forever begin
    @(negedge clk);
    if (!baud_en) begin
      bcnt = 0;
      baud_pulse = 1'b0;
    end else begin
      baud_pulse = (bcnt == 7);
      bcnt = (bcnt + 1) % 8;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic push(input logic [3:0] op, input logic [3:0] arg);
    @(negedge clk);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = op;
    cmd.cmd_arg = arg;
    @(posedge clk);
    #1;
    cmd.cmd_valid = 1'b0;
  endtask
  task automatic wait_fall(output int start, output bit ok);
    ok = 1'b0;
    start = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (TX === 1'b0) begin
        start = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic capture(output logic [9:0] bits, output int start, output logic [2:0] cnt_at, output bit ok);
    bits = '1;
    wait_fall(start, ok);
    cnt_at = fifo_count;
    if (ok)
      for (int i = 0; i < 10; i++) begin
        repeat (i == 0 ? 4 : 8) @(posedge clk);
        #1;
        bits[i] = TX;
      end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 400 && busy !== 1'b0; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset();
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op = '0;
    cmd.cmd_arg = '0;
    reset_n = 1'b0;
    #12;
    if (TX !== 1'b1) $display("FAIL reset_tx got %b want 1", TX); else pass_cnt++; total++;
    if (cmd.cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd.cmd_ready); else pass_cnt++; total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++; total++;
    if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else pass_cnt++; total++;
    if (cmd.cmd_error !== 1'b0) $display("FAIL reset_error got %b want 0", cmd.cmd_error); else pass_cnt++; total++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic test_single();
    logic [9:0] bits; int s; logic [2:0] c; bit ok;
    baud_en = 1'b1;
    push(4'd1, 4'd3);
    if (fifo_count !== 3'd1) $display("FAIL single_count got %0d want 1", fifo_count); else pass_cnt++; total++;
    if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else pass_cnt++; total++;
    if (TX !== 1'b1) $display("FAIL single_latency got %b want 1", TX); else pass_cnt++; total++;
    capture(bits, s, c, ok);
    if (!ok) $display("FAIL single_timeout got no start bit want start bit"); else pass_cnt++; total++;
    if (bits !== 10'b1001100010) $display("FAIL single_frame got %b want %b", bits, 10'b1001100010); else pass_cnt++; total++;
    wait_idle();
    if (busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", busy); else pass_cnt++; total++;
    if (TX !== 1'b1) $display("FAIL single_tx_end got %b want 1", TX); else pass_cnt++; total++;
  endtask
  task automatic test_back_to_back();
    logic [9:0] b1, b2; int s1, s2; logic [2:0] c1, c2; bit ok1, ok2;
    baud_en = 1'b0;
    push(4'd13, 4'd1);
    push(4'd2, 4'd2);
    if (fifo_count !== 3'd2) $display("FAIL b2b_count got %0d want 2", fifo_count); else pass_cnt++; total++;
    baud_en = 1'b1;
    capture(b1, s1, c1, ok1);
    capture(b2, s2, c2, ok2);
    if (!(ok1 && ok2)) $display("FAIL b2b_timeout got %b%b want 11", ok1, ok2); else pass_cnt++; total++;
    if (b1 !== {1'b1, 8'h1D, 1'b0}) $display("FAIL b2b_frame1 got %b want %b", b1, {1'b1, 8'h1D, 1'b0}); else pass_cnt++; total++;
    if (b2 !== {1'b1, 8'h22, 1'b0}) $display("FAIL b2b_frame2 got %b want %b", b2, {1'b1, 8'h22, 1'b0}); else pass_cnt++; total++;
    if (c1 !== 3'd1) $display("FAIL b2b_count1 got %0d want 1", c1); else pass_cnt++; total++;
    if (c2 !== 3'd0) $display("FAIL b2b_count0 got %0d want 0", c2); else pass_cnt++; total++;
    if (s2 - s1 !== 80) $display("FAIL b2b_gap got %0d clks want 80", s2 - s1); else pass_cnt++; total++;
    wait_idle();
  endtask
  task automatic test_full();
    logic [9:0] b; int s; logic [2:0] c; bit ok;
    baud_en = 1'b0;
    for (int i = 0; i < 4; i++) push(4'd1, 4'(i));
    if (cmd.cmd_ready !== 1'b0) $display("FAIL full_ready got %b want 0", cmd.cmd_ready); else pass_cnt++; total++;
    if (fifo_count !== 3'd4) $display("FAIL full_count got %0d want 4", fifo_count); else pass_cnt++; total++;
    if (busy !== 1'b1) $display("FAIL full_busy got %b want 1", busy); else pass_cnt++; total++;
    push(4'd1, 4'd4);
    if (fifo_count !== 3'd4) $display("FAIL full_overflow_count got %0d want 4", fifo_count); else pass_cnt++; total++;
    if (TX !== 1'b1) $display("FAIL full_tx_idle got %b want 1", TX); else pass_cnt++; total++;
    baud_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      capture(b, s, c, ok);
      if (b !== {1'b1, 4'(i), 4'h1, 1'b0}) $display("FAIL full_drain%0d got %b want %b", i, b, {1'b1, 4'(i), 4'h1, 1'b0}); else pass_cnt++; total++;
    end
    wait_idle();
    if (busy !== 1'b0) $display("FAIL full_drained_busy got %b want 0", busy); else pass_cnt++; total++;
  endtask
  task automatic test_reset_mid();
    logic [9:0] b; int s; logic [2:0] c; bit ok;
    baud_en = 1'b1;
    push(4'd1, 4'd5);
    push(4'd2, 4'd7);
    wait_fall(s, ok);
    if (!ok) $display("FAIL rmid_timeout got no start bit want start bit"); else pass_cnt++; total++;
    repeat (34) @(posedge clk);
    #1;
    if (TX !== 1'b0) $display("FAIL rmid_bit3 got %b want 0", TX); else pass_cnt++; total++;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    if (TX !== 1'b1) $display("FAIL rmid_tx got %b want 1", TX); else pass_cnt++; total++;
    if (fifo_count !== 3'd0) $display("FAIL rmid_count got %0d want 0", fifo_count); else pass_cnt++; total++;
    if (cmd.cmd_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", cmd.cmd_ready); else pass_cnt++; total++;
    @(negedge clk);
    reset_n = 1'b1;
    push(4'd2, 4'd2);
    capture(b, s, c, ok);
    if (b !== {1'b1, 8'h22, 1'b0}) $display("FAIL rmid_clean got %b want %b", b, {1'b1, 8'h22, 1'b0}); else pass_cnt++; total++;
    wait_idle();
    if (busy !== 1'b0) $display("FAIL rmid_lost_queue got busy %b want 0", busy); else pass_cnt++; total++;
  endtask
  task automatic test_opcode();
    baud_en = 1'b1;
    push(4'd5, 4'd0);
`ifdef CORRELATOR_CMD_TX_CHECK_EN
    begin
      bit low = 1'b0;
      if (cmd.cmd_error !== 1'b1) $display("FAIL op_error got %b want 1", cmd.cmd_error); else pass_cnt++; total++;
      if (fifo_count !== 3'd0) $display("FAIL op_count got %0d want 0", fifo_count); else pass_cnt++; total++;
      @(posedge clk);
      #1;
      if (cmd.cmd_error !== 1'b0) $display("FAIL op_error_pulse got %b want 0", cmd.cmd_error); else pass_cnt++; total++;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk);
        #1;
        if (TX !== 1'b1) low = 1'b1;
      end
      if (low) $display("FAIL op_tx_idle got activity want idle"); else pass_cnt++; total++;
    end
`else
    begin
      logic [9:0] b; int s; logic [2:0] c; bit ok;
      if (cmd.cmd_error !== 1'b0) $display("FAIL op_error got %b want 0", cmd.cmd_error); else pass_cnt++; total++;
      if (fifo_count !== 3'd1) $display("FAIL op_count got %0d want 1", fifo_count); else pass_cnt++; total++;
      capture(b, s, c, ok);
      if (b !== {1'b1, 8'h05, 1'b0}) $display("FAIL op_frame got %b want %b", b, {1'b1, 8'h05, 1'b0}); else pass_cnt++; total++;
    end
`endif
    wait_idle();
  endtask
  task automatic test_stop_coincident();
    logic [9:0] b1, b2; int s1, s2; logic [2:0] c; bit ok;
    baud_en = 1'b1;
    push(4'd2, 4'd9);
    capture(b1, s1, c, ok);
    if (b1 !== {1'b1, 8'h92, 1'b0}) $display("FAIL coin_frame1 got %b want %b", b1, {1'b1, 8'h92, 1'b0}); else pass_cnt++; total++;
    repeat (3) @(posedge clk);
    #1;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = 4'd1;
    cmd.cmd_arg = 4'd6;
    @(posedge clk);
    #1;
    cmd.cmd_valid = 1'b0;
    if (fifo_count !== 3'd1) $display("FAIL coin_not_popped got %0d want 1", fifo_count); else pass_cnt++; total++;
    capture(b2, s2, c, ok);
    if (b2 !== {1'b1, 8'h61, 1'b0}) $display("FAIL coin_frame2 got %b want %b", b2, {1'b1, 8'h61, 1'b0}); else pass_cnt++; total++;
    if (s2 - s1 !== 88) $display("FAIL coin_gap got %0d clks want 88", s2 - s1); else pass_cnt++; total++;
    wait_idle();
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_opcode();
    test_stop_coincident();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
